// File: rtl/controlador_ativos_pkg.sv
// Shared definitions for the active-node search controller: FSM encoding,
// operation-counter width and the popcount width helper.
package controlador_ativos_pkg;

  localparam int ESTADO_W = 3;
  typedef logic [ESTADO_W-1:0] estado_t;

  localparam estado_t OCIOSO  = 3'd0;
  localparam estado_t FONTE   = 3'd1;
  localparam estado_t AGUARDA = 3'd2;
  localparam estado_t PRONTO  = 3'd3;
  localparam estado_t COMANDO = 3'd4;
  localparam estado_t FIM     = 3'd5;

  localparam int NUM_OPS_W = 16;

  // Bits needed to hold a population count of an n-bit vector.
  function automatic int largura_contagem(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/controlador_ativos_contador_bits.sv
// contador_bits: parameterised combinational popcount.
module contador_bits #(
  parameter int W     = 8,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     bits,
  output logic [OUT_W-1:0] total
);

  always_comb begin
    total = '0;
    for (int i = 0; i < W; i++) begin
      total = total + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/controlador_ativos.sv
// Active-node search controller: sequences source load, LVV requests and
// manager commands. Define CA_VERIFICA_OVERFLOW_EN to refuse updates that exceed free NA slots.
module controlador_ativos
  import controlador_ativos_pkg::*;
#(
  parameter int NUM_NA     = 8,
  parameter int NUM_EA     = 8,
  parameter int ADDR_WIDTH = 5,
  localparam int CNT_W     = largura_contagem((NUM_NA > NUM_EA) ? NUM_NA : NUM_EA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio_in,
  input  logic [ADDR_WIDTH-1:0] endereco_fonte_in,
  input  logic                  lvv_desativar_req_in,
  input  logic                  lvv_atualizar_req_in,
  input  logic [NUM_EA-1:0]     lvv_vizinho_valido_in,
  output logic                  lvv_ready_out,
  input  logic [NUM_NA-1:0]     na_ativo_in,
  input  logic                  ga_ocupado_in,
  output logic                  ca_atualizar_fonte_out,
  output logic [ADDR_WIDTH-1:0] ca_endereco_fonte_out,
  output logic                  ca_desativar_out,
  output logic                  ca_atualizar_out,
  output logic                  ca_concluido_out,
  output logic                  ca_overflow_out,
  output logic [NUM_OPS_W-1:0]  ca_num_ops_out,
  output logic [ESTADO_W-1:0]   estado,
  output logic [CNT_W-1:0]      vizinhos_pedidos,
  output logic [CNT_W-1:0]      slots_livres
);

  // Handshake: a request is taken on a rising edge where lvv_ready_out is high;
  // desativar wins over a simultaneous atualizar, which the LVV must re-request.

  estado_t                 estado_q, estado_d;
  logic                    cmd_desativar_q;
  logic [ADDR_WIDTH-1:0]   endereco_q;
  logic [NUM_OPS_W-1:0]    num_ops_q;
  logic                    ready, aceita_desativar, aceita_atualizar, recusa, emite, carrega;

  assign ready            = (estado_q == PRONTO) && !ga_ocupado_in;
  assign aceita_desativar = ready && lvv_desativar_req_in;
  assign aceita_atualizar = ready && !lvv_desativar_req_in && lvv_atualizar_req_in;
  assign emite            = (estado_q == COMANDO) && !ga_ocupado_in;
  assign carrega          = (estado_q == OCIOSO) && inicio_in;

  contador_bits #(.W(NUM_EA), .OUT_W(CNT_W)) u_pedidos (
    .bits  (lvv_vizinho_valido_in),
    .total (vizinhos_pedidos)
  );

  contador_bits #(.W(NUM_NA), .OUT_W(CNT_W)) u_livres (
    .bits  (~na_ativo_in),
    .total (slots_livres)
  );

`ifdef CA_VERIFICA_OVERFLOW_EN
  logic overflow_q;
  assign recusa = vizinhos_pedidos > slots_livres;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (carrega) begin
      overflow_q <= 1'b0;
    end else if (aceita_atualizar && recusa) begin
      overflow_q <= 1'b1;
    end
  end

  assign ca_overflow_out = overflow_q;
`else
  assign recusa          = 1'b0;
  assign ca_overflow_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (inicio_in) estado_d = FONTE;
      FONTE:   estado_d = AGUARDA;
      AGUARDA: if (!ga_ocupado_in) estado_d = PRONTO;
      PRONTO: begin
        if (aceita_desativar)                 estado_d = COMANDO;
        else if (aceita_atualizar && !recusa) estado_d = COMANDO;
        else if (ready && !lvv_atualizar_req_in && (na_ativo_in == '0)) estado_d = FIM;
      end
      COMANDO: if (emite) estado_d = AGUARDA;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    lvv_ready_out          = ready;
    ca_atualizar_fonte_out = (estado_q == FONTE);
    ca_desativar_out       = emite && cmd_desativar_q;
    ca_atualizar_out       = emite && !cmd_desativar_q;
    ca_concluido_out       = (estado_q == FIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      endereco_q      <= '0;
      num_ops_q       <= '0;
      cmd_desativar_q <= 1'b0;
    end else begin
      if (carrega) begin
        endereco_q <= endereco_fonte_in;
        num_ops_q  <= '0;
      end else if (emite && (num_ops_q != '1)) begin
        num_ops_q <= num_ops_q + NUM_OPS_W'(1);
      end
      if (aceita_desativar)      cmd_desativar_q <= 1'b1;
      else if (aceita_atualizar) cmd_desativar_q <= 1'b0;
    end
  end

  assign ca_endereco_fonte_out = endereco_q;
  assign ca_num_ops_out        = num_ops_q;
  assign estado                = estado_q;

endmodule

// File: tb/tb_controlador_ativos.sv
// Scoreboard bench for controlador_ativos: directed vectors push expected pulse
// events; a negedge monitor pops and compares every pulse the DUT emits.
module tb_controlador_ativos;

`ifdef CA_VERIFICA_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  localparam logic [1:0] EV_FONTE = 2'd0, EV_DESAT = 2'd1, EV_ATUAL = 2'd2, EV_CONCL = 2'd3;
  localparam int W = 24;

  logic        clk, rst_n;
  logic        inicio_in;
  logic [4:0]  endereco_fonte_in;
  logic        lvv_desativar_req_in, lvv_atualizar_req_in;
  logic [7:0]  lvv_vizinho_valido_in;
  logic        lvv_ready_out;
  logic [7:0]  na_ativo_in;
  logic        ga_ocupado_in;
  logic        ca_atualizar_fonte_out;
  logic [4:0]  ca_endereco_fonte_out;
  logic        ca_desativar_out, ca_atualizar_out, ca_concluido_out, ca_overflow_out;
  logic [15:0] ca_num_ops_out;
  logic [2:0]  estado;
  logic [3:0]  vizinhos_pedidos, slots_livres;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  controlador_ativos dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .inicio_in              (inicio_in),
    .endereco_fonte_in      (endereco_fonte_in),
    .lvv_desativar_req_in   (lvv_desativar_req_in),
    .lvv_atualizar_req_in   (lvv_atualizar_req_in),
    .lvv_vizinho_valido_in  (lvv_vizinho_valido_in),
    .lvv_ready_out          (lvv_ready_out),
    .na_ativo_in            (na_ativo_in),
    .ga_ocupado_in          (ga_ocupado_in),
    .ca_atualizar_fonte_out (ca_atualizar_fonte_out),
    .ca_endereco_fonte_out  (ca_endereco_fonte_out),
    .ca_desativar_out       (ca_desativar_out),
    .ca_atualizar_out       (ca_atualizar_out),
    .ca_concluido_out       (ca_concluido_out),
    .ca_overflow_out        (ca_overflow_out),
    .ca_num_ops_out         (ca_num_ops_out),
    .estado                 (estado),
    .vizinhos_pedidos       (vizinhos_pedidos),
    .slots_livres           (slots_livres)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [1:0] k, input logic [4:0] a,
                                      input logic [15:0] o, input logic v);
    return {k, a, o, v};
  endfunction

  // Monitor: every pulse must match the head of the expected queue.
  int           npulse;
  logic [1:0]   kind;
  logic [W-1:0] act_ev, exp_ev;
  always @(negedge clk) begin
    if (rst_n) begin
      npulse = int'(ca_atualizar_fonte_out) + int'(ca_desativar_out) +
               int'(ca_atualizar_out) + int'(ca_concluido_out);
      if (npulse > 0) begin
        check("pulse_onehot", npulse, 1);
        kind = ca_desativar_out ? EV_DESAT : ca_atualizar_out ? EV_ATUAL :
               ca_concluido_out ? EV_CONCL : EV_FONTE;
        act_ev = ev(kind, ca_endereco_fonte_out, ca_num_ops_out, ca_overflow_out);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: got %0h expected none (t=%0t)", act_ev, $time);
        end else begin
          exp_ev = exp_q.pop_front();
          check("pulse_event", act_ev, exp_ev);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_ready(input string nome);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (lvv_ready_out) ok = 1'b1;
    end
    check(nome, 32'(ok), 1);
  endtask

  task automatic pedido(input bit desat, input bit atual, input logic [7:0] mask);
    lvv_desativar_req_in  = desat;
    lvv_atualizar_req_in  = atual;
    lvv_vizinho_valido_in = mask;
    @(posedge clk);
    #1;
    lvv_desativar_req_in = 1'b0;
    lvv_atualizar_req_in = 1'b0;
  endtask

  logic [15:0] ops_esp;

  initial begin
    rst_n = 1'b0;
    inicio_in = 1'b0;
    endereco_fonte_in = '0;
    lvv_desativar_req_in = 1'b0;
    lvv_atualizar_req_in = 1'b0;
    lvv_vizinho_valido_in = '0;
    na_ativo_in = 8'h01;
    ga_ocupado_in = 1'b0;

    #12;
    check("rst_ready", 32'(lvv_ready_out), 0);
    check("rst_pulses", {ca_atualizar_fonte_out, ca_desativar_out, ca_atualizar_out, ca_concluido_out}, 0);
    check("rst_addr", 32'(ca_endereco_fonte_out), 0);
    check("rst_ops", 32'(ca_num_ops_out), 0);
    check("rst_ovf", 32'(ca_overflow_out), 0);
    check("rst_state", 32'(estado), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Start with source 3; manager busy after the load
    exp_q.push_back(ev(EV_FONTE, 5'd3, 16'd0, 1'b0));
    @(posedge clk); #1;
    inicio_in = 1'b1;
    endereco_fonte_in = 5'd3;
    @(posedge clk); #1;
    inicio_in = 1'b0;
    ga_ocupado_in = 1'b1;
    repeat (3) @(negedge clk);
    check("start_ready_busy", 32'(lvv_ready_out), 0);
    check("start_state_aguarda", 32'(estado), 2);
    @(posedge clk); #1 ga_ocupado_in = 1'b0;
    wait_ready("start_ready_rise");
    check("start_state_pronto", 32'(estado), 3);

    // Simultaneous requests: only desativar is issued
    exp_q.push_back(ev(EV_DESAT, 5'd3, 16'd0, 1'b0));
    pedido(1'b1, 1'b1, 8'h01);
    @(posedge clk); #1;
    check("simul_ops", 32'(ca_num_ops_out), 1);

    // Busy hold with a pending request and a stray inicio
    ga_ocupado_in = 1'b1;
    lvv_atualizar_req_in = 1'b1;
    lvv_vizinho_valido_in = 8'h01;
    inicio_in = 1'b1;
    endereco_fonte_in = 5'd9;
    @(posedge clk); #1 inicio_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_ready", 32'(lvv_ready_out), 0);
    end
    check("busy_ops", 32'(ca_num_ops_out), 1);
    check("busy_addr_kept", 32'(ca_endereco_fonte_out), 3);
    exp_q.push_back(ev(EV_ATUAL, 5'd3, 16'd1, 1'b0));
    @(posedge clk); #1 ga_ocupado_in = 1'b0;
    wait_ready("busy_release_ready");
    @(posedge clk); #1 lvv_atualizar_req_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("atual_ops", 32'(ca_num_ops_out), 2);

    // Exactly as many neighbours as free slots: not an overflow
    wait_ready("eq_ready");
    na_ativo_in = 8'hFC;
    exp_q.push_back(ev(EV_ATUAL, 5'd3, 16'd2, 1'b0));
    pedido(1'b0, 1'b1, 8'h03);
    @(posedge clk); @(negedge clk);
    check("eq_ops", 32'(ca_num_ops_out), 3);
    check("eq_ovf", 32'(ca_overflow_out), 0);

    // One neighbour more than free slots
    wait_ready("ovf_ready");
    na_ativo_in = 8'hFE;
    if (!OVF_ON) exp_q.push_back(ev(EV_ATUAL, 5'd3, 16'd3, 1'b0));
    pedido(1'b0, 1'b1, 8'h03);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ops_esp = OVF_ON ? 16'd3 : 16'd4;
    check("ovf_flag", 32'(ca_overflow_out), 32'(OVF_ON));
    check("ovf_ops", 32'(ca_num_ops_out), 32'(ops_esp));
    check("ovf_state_pronto", 32'(estado), 3);

    // Completion
    exp_q.push_back(ev(EV_CONCL, 5'd3, ops_esp, OVF_ON));
    na_ativo_in = 8'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("fim_state_ocioso", 32'(estado), 0);
    check("fim_ovf_sticky", 32'(ca_overflow_out), 32'(OVF_ON));
    check("fim_ready", 32'(lvv_ready_out), 0);

    // Restart clears counters and overflow, then reset lands in COMANDO
    exp_q.push_back(ev(EV_FONTE, 5'd17, 16'd0, 1'b0));
    @(posedge clk); #1;
    inicio_in = 1'b1;
    endereco_fonte_in = 5'd17;
    na_ativo_in = 8'h0F;
    @(posedge clk); #1 inicio_in = 1'b0;
    wait_ready("restart_ready");
    check("restart_ovf_clear", 32'(ca_overflow_out), 0);
    lvv_atualizar_req_in = 1'b1;
    lvv_vizinho_valido_in = 8'h01;
    @(posedge clk); #1;
    check("pre_rst_state_comando", 32'(estado), 4);
    rst_n = 1'b0;
    lvv_atualizar_req_in = 1'b0;
    #1;
    check("async_rst_pulses", {ca_atualizar_fonte_out, ca_desativar_out, ca_atualizar_out, ca_concluido_out}, 0);
    check("async_rst_addr", 32'(ca_endereco_fonte_out), 0);
    check("async_rst_ops", 32'(ca_num_ops_out), 0);
    check("async_rst_state", 32'(estado), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_ready", 32'(lvv_ready_out), 0);
    end
    check("post_rst_state", 32'(estado), 0);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
